mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the control unit's MOV/MOC handshake.
- The control unit asserts mov with an address, size and direction. The microcode then waits on moc through the Condition_Mux moc input.
- This block performs the byte-addressed, big-endian RAM access after a programmable latency, asserts moc, and holds it until mov drops.
- It models the data memory and instruction memory the datapath talks to.

Parameters:
- ADDR_WIDTH, 9, byte-address width; memory depth is 2**ADDR_WIDTH bytes.
- LATENCY, 2, clock edges from mov acceptance to moc assertion; legal range 1 to 15.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- mov  input  1  memory operation valid; held high by the initiator until moc is seen
- rw  input  1  1 = read, 0 = write
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved
- se  input  1  sign-extend byte/halfword reads when 1; zero-extend when 0
- addr  input  ADDR_WIDTH  byte address
- data_in  input  32  write data; right-justified for byte/halfword
- moc  output  1  memory operation complete
- data_out  output  32  read data
- err  output  1  alignment/size error flag, valid while moc=1

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-low (reset_n), sampled on the rising edge.
  - Reset: state=IDLE, moc=0, err=0, data_out=32'h0, counter=0.
  - Memory array is not cleared by reset.
- IDLE:
  - On an edge with mov=1: latch rw, size, se, addr, data_in; cnt<=1; go WAIT.
  - mov=0 keeps IDLE.
- WAIT:
  - If cnt==LATENCY: perform the access, moc<=1, go DONE.
  - Otherwise cnt<=cnt+1.
  - Request edge k, so moc is first high after edge k+LATENCY.
  - Inputs other than the latched copies are ignored in WAIT. A mov drop in WAIT does not cancel the op.
- DONE:
  - moc stays 1 while mov=1.
  - First edge with mov=0: moc<=0, err<=0, go IDLE.
  - A new request is accepted no earlier than the edge after IDLE is re-entered; minimum one idle cycle between ops.
- Access, big-endian:
  - Byte addr holds bits [31:24] of a word at addr, addr+1 holds [23:16], and so on.
  - Write byte: mem[a]=data_in[7:0].
  - Write halfword: mem[a]=data_in[15:8], mem[a+1]=data_in[7:0].
  - Write word: four bytes, MSB first.
  - Writes commit only on the edge moc rises.
  - Read: data_out is loaded on the edge moc rises, extended per se, and held until the next successful read completes. Writes and errored ops leave data_out unchanged.
- Alignment:
  - Halfword needs addr[0]=0. Word needs addr[1:0]=00.
  - A violation, or size=11, gives: no memory change, data_out unchanged, err=1 together with moc. The handshake completes normally.
- Address wrap: addresses are ADDR_WIDTH bits. An aligned access never crosses the top, so there is no wrap case.
- Reset mid-operation: abort to IDLE. No write is committed from WAIT. moc drops on that edge.
- mov high continuously across DONE→IDLE is not a new request. mov must be sampled low at least once (the DONE exit) before re-acceptance.

Test Plan:
- Word write then read, LATENCY=2:
  - Write 32'hDEADBEEF at addr 0x010 → moc high exactly 2 edges after acceptance, err=0.
  - Word read at 0x010 → data_out=32'hDEADBEEF.
- Byte reads of that word:
  - Byte read 0x011, se=1 → 32'hFFFFFFAD.
  - Byte read 0x011, se=0 → 32'h000000AD.
  - Byte read 0x013, se=1 → 32'hFFFFFFEF.
- Halfword write and read:
  - Halfword write 16'h1234 at 0x012, then word read 0x010 → 32'hDEAD1234.
  - Halfword read 0x012, se=1 → 32'h00001234.
- Misaligned word write 32'h0 at 0x013 → err=1 with moc; word read 0x010 still 32'hDEAD1234; data_out unchanged across the errored op.
- Handshake timing, LATENCY=3:
  - moc rises on the 3rd edge after acceptance.
  - Hold mov 5 more cycles → moc stays 1; drop mov → moc 0 after the next edge.
  - mov dropped during WAIT → moc is a single-cycle pulse and the write still commits.
- Reset mid-operation: reset_n=0 during WAIT of a word write 32'hCAFEF00D to 0x020 → moc=0, state IDLE; a later read of 0x020 returns the prior contents (write 32'h0 first).

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the control unit's MOV/MOC handshake. A request
// (mov=1) is latched in IDLE. After LATENCY clock edges the byte-addressed,
// big-endian access is performed against an internal byte array and moc is
// raised. moc stays high until the initiator drops mov. Misaligned or reserved
// size requests complete the handshake with err=1 and have no side effects.
//
// Parameters
//   ADDR_WIDTH : byte-address width; memory depth is 2**ADDR_WIDTH bytes (>= 2)
//   LATENCY    : clock edges from mov acceptance to moc assertion (1..15)
//
// Ports
//   clk      in   1           rising-edge clock
//   reset_n  in   1           synchronous active-low reset
//   mov      in   1           memory operation valid
//   rw       in   1           1 = read, 0 = write
//   size     in   2           00 byte, 01 halfword, 10 word, 11 reserved
//   se       in   1           sign-extend byte/halfword reads
//   addr     in   ADDR_WIDTH  byte address
//   data_in  in   32          write data, right-justified for byte/halfword
//   moc      out  1           memory operation complete (registered)
//   data_out out  32          read data (registered, held between reads)
//   err      out  1           alignment/size error, valid while moc=1
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mov,
    input  logic                  rw,
    input  logic [1:0]            size,
    input  logic                  se,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data_in,
    output logic                  moc,
    output logic [31:0]           data_out,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Zero- or sign-extend a byte to 32 bits.
    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sx);
        logic [31:0] r;
        if (sx) begin
            r = {{24{b[7]}}, b};
        end else begin
            r = {24'h000000, b};
        end
        return r;
    endfunction

    // Zero- or sign-extend a halfword to 32 bits.
    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sx);
        logic [31:0] r;
        if (sx) begin
            r = {{16{h[15]}}, h};
        end else begin
            r = {16'h0000, h};
        end
        return r;
    endfunction

    // Natural-alignment check; the reserved size always reports an error.
    function automatic logic is_bad_access(input logic [1:0] sz, input logic [1:0] lo);
        logic r;
        case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            SZ_WORD: r = (lo != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State and storage
    // -------------------------------------------------------------------------
    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic                  rw_r;
    logic [1:0]            size_r;
    logic                  se_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic                  moc_r;
    logic                  err_r;
    logic [31:0]           dout_r;

    logic [7:0]            mem_r [0:DEPTH-1];

    // -------------------------------------------------------------------------
    // Combinational access path
    // -------------------------------------------------------------------------
    logic                  fire_s;
    logic                  bad_s;
    logic [ADDR_WIDTH-1:0] lane_idx_s [4];
    logic [7:0]            rd_byte_s  [4];
    logic [7:0]            lane_wd_s  [4];
    logic [3:0]            lane_we_s;
    logic [31:0]           rd_data_s;

    // Access fires on the WAIT edge where the latency count is reached.
    always_comb begin
        fire_s = (state_r == ST_WAIT) && (cnt_r == LAT_C);
        bad_s  = is_bad_access(size_r, addr_r[1:0]);
    end

    // Byte lane i of an aligned access lives at addr | i; alignment
    // guarantees the OR never carries, so no access crosses the top.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_idx_s[i] = {addr_r[ADDR_WIDTH-1:2], addr_r[1:0] | 2'(i)};
            rd_byte_s[i]  = mem_r[lane_idx_s[i]];
        end
    end

    // Assemble the big-endian read value (lane 0 is the most significant).
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (size_r)
            SZ_BYTE: rd_data_s = extend_byte(rd_byte_s[0], se_r);
            SZ_HALF: rd_data_s = extend_half({rd_byte_s[0], rd_byte_s[1]}, se_r);
            SZ_WORD: rd_data_s = {rd_byte_s[0], rd_byte_s[1], rd_byte_s[2], rd_byte_s[3]};
            default: rd_data_s = 32'h0000_0000;
        endcase
    end

    // Route right-justified write data onto byte lanes, MSB first.
    always_comb begin
        lane_we_s    = 4'b0000;
        lane_wd_s[0] = 8'h00;
        lane_wd_s[1] = 8'h00;
        lane_wd_s[2] = 8'h00;
        lane_wd_s[3] = 8'h00;
        case (size_r)
            SZ_BYTE: begin
                lane_we_s    = 4'b0001;
                lane_wd_s[0] = wdata_r[7:0];
            end
            SZ_HALF: begin
                lane_we_s    = 4'b0011;
                lane_wd_s[0] = wdata_r[15:8];
                lane_wd_s[1] = wdata_r[7:0];
            end
            SZ_WORD: begin
                lane_we_s    = 4'b1111;
                lane_wd_s[0] = wdata_r[31:24];
                lane_wd_s[1] = wdata_r[23:16];
                lane_wd_s[2] = wdata_r[15:8];
                lane_wd_s[3] = wdata_r[7:0];
            end
            default: begin
                lane_we_s = 4'b0000;
            end
        endcase
        // Commit only on the moc-rise edge of a clean write; reset wins.
        if (!(fire_s && !rw_r && !bad_s && reset_n)) begin
            lane_we_s = 4'b0000;
        end else begin
            lane_we_s = lane_we_s;
        end
    end

    // Byte-array write port; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we_s[i]) begin
                mem_r[lane_idx_s[i]] <= lane_wd_s[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake FSM
    // -------------------------------------------------------------------------

    // Request latch, latency counter and registered moc/err/data_out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            rw_r    <= 1'b0;
            size_r  <= 2'b00;
            se_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            moc_r   <= 1'b0;
            err_r   <= 1'b0;
            dout_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mov) begin
                        rw_r    <= rw;
                        size_r  <= size;
                        se_r    <= se;
                        addr_r  <= addr;
                        wdata_r <= data_in;
                        cnt_r   <= 4'd1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // mov and the live request inputs are ignored here; the
                    // latched copies drive the access.
                    if (fire_s) begin
                        moc_r   <= 1'b1;
                        err_r   <= bad_s;
                        if (rw_r && !bad_s) begin
                            dout_r <= rd_data_s;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    // mov must be seen low here before another request can
                    // be accepted, so a mov held high is never re-accepted.
                    if (!mov) begin
                        moc_r   <= 1'b0;
                        err_r   <= 1'b0;
                        cnt_r   <= 4'd0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    moc_r   <= 1'b0;
                    err_r   <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign moc      = moc_r;
    assign err      = err_r;
    assign data_out = dout_r;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Scoreboard bench for mem_responder. Each issued request is evaluated against
// a byte-array reference model; the expected moc-rise edge, err and data_out
// are queued, along with the expected moc-fall edge. An independent monitor
// pops and compares whenever moc changes.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AW  = 9;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mov;
    logic          rw;
    logic [1:0]    size;
    logic          se;
    logic [AW-1:0] addr;
    logic [31:0]   data_in;
    logic          moc;
    logic [31:0]   data_out;
    logic          err;

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mov      (mov),
        .rw       (rw),
        .size     (size),
        .se       (se),
        .addr     (addr),
        .data_in  (data_in),
        .moc      (moc),
        .data_out (data_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Rising-edge counter: after edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_no;
        logic        err;
        logic [31:0] dout;
    } rsp_t;

    rsp_t rise_q[$];
    int   fall_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    logic [31:0] ref_dout;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an access of 2**size bytes must start on a multiple
    // of its length; byte a holds the most significant byte of the value.
    task automatic model_op(input logic m_rw, input logic [1:0] m_size, input logic m_se,
                            input logic [AW-1:0] m_addr, input logic [31:0] m_data,
                            output logic m_err);
        int          nb;
        int          a;
        logic [31:0] v;
        logic [31:0] t;
        nb    = 1 << m_size;
        a     = int'(m_addr);
        m_err = (m_size == 2'b11) || ((a % nb) != 0);
        if (!m_err) begin
            if (!m_rw) begin
                for (int i = 0; i < nb; i++) begin
                    t = m_data >> (8 * (nb - 1 - i));
                    ref_mem[a + i] = t[7:0];
                end
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) begin
                    v = (v << 8) | {24'h0, ref_mem[a + i]};
                end
                if (m_se && nb < 4 && v[8 * nb - 1]) begin
                    v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                end
                ref_dout = v;
            end
        end
    endtask

    // Wait (bounded) at negedges until moc reaches the given level.
    task automatic wait_moc(input logic lvl);
        int n = 0;
        while (moc !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (moc !== lvl) begin
            n_cmp++;
            n_bad++;
            $display("FAIL moc_timeout: moc stuck at %b, expected %b", moc, lvl);
        end
    endtask

    // Randomise the request inputs (other than mov); used while the DUT is
    // busy to confirm only the latched copies matter.
    task automatic scramble();
        logic [31:0] rnd;
        rnd     = $urandom;
        addr    = rnd[AW-1:0];
        size    = rnd[13:12];
        rw      = rnd[14];
        se      = rnd[15];
        data_in = $urandom;
    endtask

    // Issue one request. hold = extra cycles mov stays high after moc is
    // seen; drop_early drops mov in WAIT (moc must then be a 1-cycle pulse).
    task automatic do_op(input logic o_rw, input logic [1:0] o_size, input logic o_se,
                         input logic [AW-1:0] o_addr, input logic [31:0] o_data,
                         input int hold, input bit drop_early);
        rsp_t r;
        int   k;
        logic e;
        model_op(o_rw, o_size, o_se, o_addr, o_data, e);
        r.err  = e;
        r.dout = ref_dout;
        @(negedge clk);
        mov     = 1'b1;
        rw      = o_rw;
        size    = o_size;
        se      = o_se;
        addr    = o_addr;
        data_in = o_data;
        k         = cyc + 1;
        r.edge_no = k + LAT;
        rise_q.push_back(r);
        @(negedge clk);
        scramble();
        if (drop_early) begin
            mov = 1'b0;
            fall_q.push_back(k + LAT + 1);
            wait_moc(1'b1);
            wait_moc(1'b0);
        end else begin
            wait_moc(1'b1);
            repeat (hold) @(negedge clk);
            mov = 1'b0;
            fall_q.push_back(cyc + 1);
            wait_moc(1'b0);
        end
    endtask

    // Monitor: compare on every moc transition, sampled at the falling edge.
    logic moc_q = 1'b0;
    always @(negedge clk) begin
        rsp_t r;
        if (moc === 1'b1 && moc_q !== 1'b1) begin
            if (rise_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_moc: moc rose at edge %0d with nothing pending", cyc);
            end else begin
                r = rise_q.pop_front();
                chk_int("moc_rise_edge", cyc, r.edge_no);
                chk1("err", err, r.err);
                chk32("data_out", data_out, r.dout);
            end
        end else if (moc === 1'b0 && moc_q === 1'b1) begin
            if (fall_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_moc_fall: moc fell at edge %0d", cyc);
            end else begin
                chk_int("moc_fall_edge", cyc, fall_q.pop_front());
                chk1("err_cleared", err, 1'b0);
            end
        end
        moc_q <= moc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        logic [AW-1:0] ra;
        reset_n = 1'b0;
        mov     = 1'b0;
        rw      = 1'b0;
        size    = 2'b00;
        se      = 1'b0;
        addr    = '0;
        data_in = 32'h0;
        ref_dout = 32'h0;
        repeat (3) @(negedge clk);
        chk1("reset_moc", moc, 1'b0);
        chk1("reset_err", err, 1'b0);
        chk32("reset_data_out", data_out, 32'h0);
        reset_n = 1'b1;

        // Word write / read and big-endian byte/halfword views.
        do_op(1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 0, 1'b0);
        do_op(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b00, 1'b1, 9'h011, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b00, 1'b0, 9'h011, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b00, 1'b1, 9'h013, 32'h0, 0, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 9'h012, 32'h00001234, 0, 1'b0);
        do_op(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b01, 1'b1, 9'h012, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b01, 1'b1, 9'h010, 32'h0, 0, 1'b0);

        // Errored ops: misaligned word write, misaligned halfword read,
        // reserved size read. data_out must not move.
        do_op(1'b0, 2'b10, 1'b0, 9'h013, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b01, 1'b1, 9'h011, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b11, 1'b0, 9'h010, 32'h0, 0, 1'b0);
        do_op(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, 1'b0);

        // mov held 5 extra cycles in DONE, then mov dropped during WAIT.
        do_op(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 5, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 9'h014, 32'h5555AAAA, 0, 1'b1);
        do_op(1'b1, 2'b10, 1'b0, 9'h014, 32'h0, 0, 1'b0);

        // Reset during WAIT of a write: nothing committed, moc stays low.
        do_op(1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 0, 1'b0);
        @(negedge clk);
        mov     = 1'b1;
        rw      = 1'b0;
        size    = 2'b10;
        se      = 1'b0;
        addr    = 9'h020;
        data_in = 32'hCAFEF00D;
        @(negedge clk);
        mov     = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk1("midreset_moc", moc, 1'b0);
        chk1("midreset_err", err, 1'b0);
        chk32("midreset_data_out", data_out, 32'h0);
        ref_dout = 32'h0;
        reset_n  = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        chk1("midreset_no_moc", moc, 1'b0);
        do_op(1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 0, 1'b0);

        // Randomised traffic over an initialised 32-byte window.
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, 2'b10, 1'b0, 9'(9'h040 + 4 * i), $urandom, 0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            rnd = $urandom;
            ra  = 9'h040 + {4'b0000, rnd[4:0]};
            do_op(rnd[5], rnd[7:6], rnd[8], ra, $urandom, int'(rnd[10:9]), rnd[13:11] == 3'b000);
        end

        repeat (5) @(negedge clk);
        chk_int("rise_queue_drained", rise_q.size(), 0);
        chk_int("fall_queue_drained", fall_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
